// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller: time-multiplexed 7-segment scan driver with frame-synchronous
// shadow loading, per-digit enable/decimal point/blink and PWM brightness.
module sseg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 65536,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [7*NUM_DIGITS-1:0] seg_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   en_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    input  logic [BRIGHT_W-1:0]     bright_i,
    input  logic                    load_i,
    output logic                    pending_o,
    output logic                    frame_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              sseg_o,
    output logic                    dp_o
);
    localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW  = $clog2(NUM_DIGITS);
    localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int SUB = PRESCALE >> BRIGHT_W;

    logic [PW-1:0]                 r_pcnt;
    logic [IW-1:0]                 r_idx;
    logic [FW-1:0]                 r_fcnt;
    logic                          r_blink_ph;
    logic                          r_pending;
    logic [NUM_DIGITS-1:0][6:0]    r_pnd_seg;
    logic [NUM_DIGITS-1:0]         r_pnd_dp;
    logic [NUM_DIGITS-1:0]         r_pnd_en;
    logic [NUM_DIGITS-1:0]         r_pnd_blink;
    logic [BRIGHT_W-1:0]           r_pnd_bright;
    logic [NUM_DIGITS-1:0][6:0]    r_act_seg;
    logic [NUM_DIGITS-1:0]         r_act_dp;
    logic [NUM_DIGITS-1:0]         r_act_en;
    logic [NUM_DIGITS-1:0]         r_act_blink;
    logic [BRIGHT_W-1:0]           r_act_bright;
    logic                          r_frame;
    logic [NUM_DIGITS-1:0]         r_an;
    logic [6:0]                    r_sseg;
    logic                          r_dp;

    logic                          w_slot_wrap;
    logic                          w_frame_wrap;
    logic                          w_blink_wrap;
    logic [PW-1:0]                 w_phase;
    logic                          w_pwm_on;
    logic                          w_vis;

    assign w_slot_wrap  = r_pcnt == PW'(PRESCALE - 1);
    assign w_frame_wrap = w_slot_wrap && (r_idx == IW'(NUM_DIGITS - 1));
    assign w_blink_wrap = r_fcnt == FW'(BLINK_FRAMES - 1);
    assign w_phase      = r_pcnt / PW'(SUB);
    assign w_pwm_on     = (&r_act_bright) || (w_phase < PW'(r_act_bright));
    assign w_vis        = r_act_en[r_idx] && w_pwm_on && !(r_act_blink[r_idx] && r_blink_ph);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pcnt <= '0;
            r_idx  <= '0;
        end else begin
            r_pcnt <= w_slot_wrap ? '0 : r_pcnt + 1'b1;
            if (w_slot_wrap)
                r_idx <= w_frame_wrap ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fcnt     <= '0;
            r_blink_ph <= 1'b0;
        end else if (w_frame_wrap) begin
            r_fcnt <= w_blink_wrap ? '0 : r_fcnt + 1'b1;
            if (w_blink_wrap)
                r_blink_ph <= ~r_blink_ph;
        end
    end

    // A load coinciding with a boundary stays pending: the old set is promoted first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending    <= 1'b0;
            r_pnd_seg    <= '0;
            r_pnd_dp     <= '0;
            r_pnd_en     <= '0;
            r_pnd_blink  <= '0;
            r_pnd_bright <= '0;
        end else begin
            r_pending <= load_i || (r_pending && !w_frame_wrap);
            if (load_i) begin
                r_pnd_seg    <= seg_i;
                r_pnd_dp     <= dp_i;
                r_pnd_en     <= en_i;
                r_pnd_blink  <= blink_i;
                r_pnd_bright <= bright_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_act_seg    <= '0;
            r_act_dp     <= '0;
            r_act_en     <= '0;
            r_act_blink  <= '0;
            r_act_bright <= '0;
        end else if (w_frame_wrap && r_pending) begin
            r_act_seg    <= r_pnd_seg;
            r_act_dp     <= r_pnd_dp;
            r_act_en     <= r_pnd_en;
            r_act_blink  <= r_pnd_blink;
            r_act_bright <= r_pnd_bright;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame <= 1'b0;
            r_an    <= '1;
            r_sseg  <= 7'h7F;
            r_dp    <= 1'b1;
        end else begin
            r_frame <= w_frame_wrap;
            r_an    <= w_vis ? ~(NUM_DIGITS'(1) << r_idx) : '1;
            r_sseg  <= w_vis ? r_act_seg[r_idx] : 7'h7F;
            r_dp    <= w_vis ? ~r_act_dp[r_idx] : 1'b1;
        end
    end

    assign pending_o = r_pending;
    assign frame_o   = r_frame;
    assign an_o      = r_an;
    assign sseg_o    = r_sseg;
    assign dp_o      = r_dp;
endmodule
